// File: rtl/hadamard_product_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hadamard_product_pipe
// Description : Pipelined element-wise (Hadamard) multiplier for the
//               convolution datapath. Multiplies SIZE kernel/patch element
//               pairs, keeps the full-width product through LATENCY register
//               stages under a global valid/ready stall, then rescales by
//               FRAC_BITS and narrows each product to WIDTH bits.
//               Optional feature macro: HADAMARD_PRODUCT_SATURATE_EN
//                 defined   -> narrowing clamps to the WIDTH range, sat flags
//                 undefined -> narrowing wraps, sat tied to 0
// Revision    : 1.0 - initial release
// ============================================================================
module hadamard_product_pipe #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 9,
    parameter int LATENCY   = 2,
    parameter int SIGNED    = 1,
    parameter int FRAC_BITS = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SIZE-1:0][WIDTH-1:0]   kernel,
    input  logic [SIZE-1:0][WIDTH-1:0]   patch,
    input  logic                         buffer_valid,
    output logic                         buffer_ready,
    output logic                         mul_valid,
    input  logic                         mul_ready,
    output logic [SIZE-1:0][WIDTH-1:0]   dout,
    output logic [SIZE-1:0]              sat
);

    // Full product width; the pipeline carries this untouched so the rescale
    // sees every bit of the exact product.
    localparam int c_prod_w = 2 * WIDTH;

    // ------------------------------------------------------------------------
    // Multiplier array
    // ------------------------------------------------------------------------
    // Operands are extended to the product width explicitly (sign or zero),
    // so a plain unsigned multiply of the extended values yields the exact
    // product in the low c_prod_w bits for both operand interpretations.
    logic [SIZE-1:0][c_prod_w-1:0] w_prod;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_mul
            logic [c_prod_w-1:0] w_k_ext;
            logic [c_prod_w-1:0] w_p_ext;

            if (SIGNED != 0) begin : g_sext
                assign w_k_ext = {{WIDTH{kernel[gi][WIDTH-1]}}, kernel[gi]};
                assign w_p_ext = {{WIDTH{patch[gi][WIDTH-1]}},  patch[gi]};
            end else begin : g_zext
                assign w_k_ext = {{WIDTH{1'b0}}, kernel[gi]};
                assign w_p_ext = {{WIDTH{1'b0}}, patch[gi]};
            end

            assign w_prod[gi] = w_k_ext * w_p_ext;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Global stall control
    // ------------------------------------------------------------------------
    // The whole pipe moves as one: it advances whenever the output register is
    // empty or being drained. Bubbles are deliberately not squeezed out.
    logic [SIZE-1:0][c_prod_w-1:0] r_prod [LATENCY];
    logic [LATENCY-1:0]            r_vld;
    logic                          w_advance;

    assign w_advance    = ~r_vld[LATENCY-1] | mul_ready;
    assign buffer_ready = w_advance;
    assign mul_valid    = r_vld[LATENCY-1];

    // Product/valid shift register: stage 0 captures the multiplier, later
    // stages shift; everything holds while stalled and clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_prod[s] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0]  <= buffer_valid;
            r_prod[0] <= w_prod;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Rescale and narrowing of the last stage
    // ------------------------------------------------------------------------
    // Output is derived directly from the last product register, so dout and
    // sat are as stable as that register during a stall and read as zero
    // after reset.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
            logic [c_prod_w-1:0] w_ps;

            if (SIGNED != 0) begin : g_sra
                // Arithmetic shift: fixed-point rescale rounding toward -inf.
                assign w_ps = $signed(r_prod[LATENCY-1][gi]) >>> FRAC_BITS;
            end else begin : g_srl
                assign w_ps = r_prod[LATENCY-1][gi] >> FRAC_BITS;
            end

`ifdef HADAMARD_PRODUCT_SATURATE_EN
            logic w_ovf;

            if (SIGNED != 0) begin : g_clamp_s
                // Representable in WIDTH bits only when the discarded upper
                // bits are all copies of the new sign bit.
                assign w_ovf = ~((&w_ps[c_prod_w-1:WIDTH-1]) |
                                 ~(|w_ps[c_prod_w-1:WIDTH-1]));
                assign dout[gi] = ~w_ovf ? w_ps[WIDTH-1:0] :
                                  (w_ps[c_prod_w-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}});
            end else begin : g_clamp_u
                assign w_ovf    = |w_ps[c_prod_w-1:WIDTH];
                assign dout[gi] = w_ovf ? {WIDTH{1'b1}} : w_ps[WIDTH-1:0];
            end

            assign sat[gi] = w_ovf;
`else
            // Wrap-around narrowing: the upper product bits are discarded.
            logic w_unused_hi;

            assign w_unused_hi = ^w_ps[c_prod_w-1:WIDTH];
            assign dout[gi]    = w_ps[WIDTH-1:0];
            assign sat[gi]     = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire
